// File: rtl/qspi_flash_arbiter.sv
// Two-requester round-robin arbiter driving one quad-SPI flash with Fast-Read-Quad (0xEB).
// Each grant runs one complete read sequence and returns a single 32-bit word to the winner.
module qspi_flash_arbiter #(
  parameter int unsigned DUMMY_CYC = 4,
  parameter logic [7:0]  MODE_BYTE = 8'hFF,
  parameter int unsigned CSH_CYC   = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  output logic        r0_gnt,
  output logic        r0_valid,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic [23:0] r1_addr,
  output logic        r1_gnt,
  output logic        r1_valid,
  output logic [31:0] r1_rdata,
  output logic        fsclk,
  output logic        fcen,
  output logic [3:0]  fdo,
  output logic        fdoe,
  input  logic [3:0]  fdi,
  output logic        busy
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [7:0]  CMD_BYTE = 8'hEB;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_MODE  = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_CSH   = 3'd6;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ph, ph_n;        // 0: next edge starts phase L, 1: next edge starts phase H
  logic             samp, samp_n;    // an fdi nibble is due on the next edge
  logic             sel, sel_n;
  logic             last, last_n;
  logic [21:0]      addr_q, addr_n;
  logic [27:0]      sreg, sreg_n;
  logic             fsclk_n, fcen_n, fdoe_n, busy_n;
  logic [3:0]       fdo_n;
  logic             r0_gnt_n, r1_gnt_n, r0_valid_n, r1_valid_n;
  logic [31:0]      r0_rdata_n, r1_rdata_n;

  logic [23:0]      addr_w;
  logic [3:0]       nib_c;
  logic [CNT_W-1:0] last_cnt_c;
  logic [2:0]       next_st_c;
  logic [31:0]      raw_c, word_c;
  logic             pick;

  // Bits [1:0] of the request addresses are dropped for word alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{r0_addr[1:0], r1_addr[1:0]};

  assign addr_w = {addr_q, 2'b00};
  assign raw_c  = {sreg, fdi};
  // First byte on the wire lands in the least significant byte.
  assign word_c = {raw_c[7:0], raw_c[15:8], raw_c[23:16], raw_c[31:24]};

  // Per-state nibble to drive, bit count and successor state.
  always_comb begin
    nib_c      = 4'hF;
    last_cnt_c = '0;
    next_st_c  = S_IDLE;
    case (state)
      S_CMD: begin
        nib_c      = {3'b111, CMD_BYTE[~cnt[2:0]]};
        last_cnt_c = CNT_W'(7);
        next_st_c  = S_ADDR;
      end
      S_ADDR: begin
        case (cnt[2:0])
          3'd0:    nib_c = addr_w[23:20];
          3'd1:    nib_c = addr_w[19:16];
          3'd2:    nib_c = addr_w[15:12];
          3'd3:    nib_c = addr_w[11:8];
          3'd4:    nib_c = addr_w[7:4];
          default: nib_c = addr_w[3:0];
        endcase
        last_cnt_c = CNT_W'(5);
        next_st_c  = S_MODE;
      end
      S_MODE: begin
        nib_c      = cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        last_cnt_c = CNT_W'(1);
        next_st_c  = S_DUMMY;
      end
      S_DUMMY: begin
        last_cnt_c = CNT_W'(DUMMY_CYC - 1);
        next_st_c  = S_DATA;
      end
      S_DATA: begin
        last_cnt_c = CNT_W'(7);
        next_st_c  = S_CSH;
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ph_n       = ph;
    samp_n     = samp;
    sel_n      = sel;
    last_n     = last;
    addr_n     = addr_q;
    sreg_n     = sreg;
    fsclk_n    = fsclk;
    fcen_n     = fcen;
    fdo_n      = fdo;
    fdoe_n     = fdoe;
    busy_n     = busy;
    r0_gnt_n   = 1'b0;
    r1_gnt_n   = 1'b0;
    r0_valid_n = 1'b0;
    r1_valid_n = 1'b0;
    r0_rdata_n = r0_rdata;
    r1_rdata_n = r1_rdata;
    pick       = 1'b0;
    case (state)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          pick     = (r0_req && r1_req) ? ~last : r1_req;
          sel_n    = pick;
          last_n   = pick;
          addr_n   = pick ? r1_addr[23:2] : r0_addr[23:2];
          r0_gnt_n = ~pick;
          r1_gnt_n = pick;
          busy_n   = 1'b1;
          state_n  = S_CMD;
          cnt_n    = '0;
          ph_n     = 1'b0;
          samp_n   = 1'b0;
        end
      end
      S_CSH: begin
        if (samp) begin
          samp_n  = 1'b0;
          fcen_n  = 1'b1;
          fsclk_n = 1'b0;
          fdoe_n  = 1'b0;
          fdo_n   = 4'hF;
          if (sel) begin
            r1_valid_n = 1'b1;
            r1_rdata_n = word_c;
          end else begin
            r0_valid_n = 1'b1;
            r0_rdata_n = word_c;
          end
        end
        if (cnt == CNT_W'(CSH_CYC - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (!ph) begin
          // This edge ends the previous phase H and starts phase L of the current SCK.
          if (samp) sreg_n = {sreg[23:0], fdi};
          samp_n  = 1'b0;
          fsclk_n = 1'b0;
          fcen_n  = 1'b0;
          fdo_n   = nib_c;
          fdoe_n  = (state != S_DUMMY) && (state != S_DATA);
          ph_n    = 1'b1;
        end else begin
          fsclk_n = 1'b1;
          ph_n    = 1'b0;
          samp_n  = (state == S_DATA);
          if (cnt == last_cnt_c) begin
            state_n = next_st_c;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ph       <= 1'b0;
      samp     <= 1'b0;
      sel      <= 1'b0;
      last     <= 1'b1;
      addr_q   <= '0;
      sreg     <= '0;
      fsclk    <= 1'b0;
      fcen     <= 1'b1;
      fdo      <= 4'hF;
      fdoe     <= 1'b0;
      busy     <= 1'b0;
      r0_gnt   <= 1'b0;
      r1_gnt   <= 1'b0;
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ph       <= ph_n;
      samp     <= samp_n;
      sel      <= sel_n;
      last     <= last_n;
      addr_q   <= addr_n;
      sreg     <= sreg_n;
      fsclk    <= fsclk_n;
      fcen     <= fcen_n;
      fdo      <= fdo_n;
      fdoe     <= fdoe_n;
      busy     <= busy_n;
      r0_gnt   <= r0_gnt_n;
      r1_gnt   <= r1_gnt_n;
      r0_valid <= r0_valid_n;
      r1_valid <= r1_valid_n;
      r0_rdata <= r0_rdata_n;
      r1_rdata <= r1_rdata_n;
    end
  end

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Directed bench for qspi_flash_arbiter: default instance plus a DUMMY_CYC=8 instance,
// each with a small behavioural flash that logs command/address and returns data nibbles.
module tb_qspi_flash_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        r0_req, r1_req;
  logic [23:0] r0_addr, r1_addr;
  logic        r0_gnt, r1_gnt, r0_valid, r1_valid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        fsclk, fcen, fdoe, busy;
  logic [3:0]  fdo;
  logic [3:0]  fdi = 4'h0;

  logic        r0_req8, r1_req8;
  logic [23:0] r0_addr8, r1_addr8;
  logic        r0_gnt8, r1_gnt8, r0_valid8, r1_valid8;
  logic [31:0] r0_rdata8, r1_rdata8;
  logic        fsclk8, fcen8, fdoe8, busy8;
  logic [3:0]  fdo8;
  logic [3:0]  fdi8 = 4'hA;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  qspi_flash_arbiter u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_valid(r0_valid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_valid(r1_valid), .r1_rdata(r1_rdata),
    .fsclk(fsclk), .fcen(fcen), .fdo(fdo), .fdoe(fdoe), .fdi(fdi), .busy(busy)
  );

  qspi_flash_arbiter #(.DUMMY_CYC(8)) u_dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .r0_req(r0_req8), .r0_addr(r0_addr8), .r0_gnt(r0_gnt8), .r0_valid(r0_valid8), .r0_rdata(r0_rdata8),
    .r1_req(r1_req8), .r1_addr(r1_addr8), .r1_gnt(r1_gnt8), .r1_valid(r1_valid8), .r1_rdata(r1_rdata8),
    .fsclk(fsclk8), .fcen(fcen8), .fdo(fdo8), .fdoe(fdoe8), .fdi(fdi8), .busy(busy8)
  );

  // Flash model for the default instance.
  logic [31:0] resp_word = 32'h0;
  logic [7:0]  cmd_log = 8'h0;
  logic [23:0] addr_log = 24'h0;
  int          sck_n = 0;
  int          sck_last = 0;
  int          hi_err = 0;

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int j);
    logic [31:0] t;
    t = w >> (8 * (j / 2) + ((j % 2 == 0) ? 4 : 0));
    return t[3:0];
  endfunction

  always @(posedge fsclk or posedge fcen) begin
    if (fcen === 1'b1) begin
      sck_last = sck_n;
      sck_n    = 0;
    end else begin
      if (sck_n < 8) begin
        cmd_log = {cmd_log[6:0], fdo[0]};
        if (fdo[3:1] !== 3'b111) hi_err++;
      end else if (sck_n < 14) begin
        addr_log = {addr_log[19:0], fdo};
      end
      if (sck_n >= 20 && sck_n < 28) fdi = nib_of(resp_word, sck_n - 20);
      sck_n++;
    end
  end

  // Flash model for the DUMMY_CYC=8 instance: watches fdoe through the dummy window.
  int sck8_n = 0;
  int sck8_last = 0;
  int dummy_err = 0;
  always @(posedge fsclk8 or posedge fcen8) begin
    if (fcen8 === 1'b1) begin
      sck8_last = sck8_n;
      sck8_n    = 0;
    end else begin
      if (sck8_n >= 16 && sck8_n < 24 && fdoe8 !== 1'b0) dummy_err++;
      if (sck8_n == 15 && fdoe8 !== 1'b1) dummy_err++;
      sck8_n++;
    end
  end

  int v0 = 0;
  int v1 = 0;
  always @(posedge HCLK) begin
    if (r0_valid === 1'b1) v0++;
    if (r1_valid === 1'b1) v1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One read on the default instance; returns gnt-to-valid latency in cycles.
  task automatic do_read(input bit r, input logic [23:0] a, input logic [31:0] resp,
                         input int drop_after, output int lat);
    int  n;
    bit  got;
    resp_word = resp;
    if (r) begin r1_addr = a; r1_req = 1'b1; end
    else   begin r0_addr = a; r0_req = 1'b1; end
    got = 1'b0;
    n   = 0;
    while (!got && n < 300) begin
      @(negedge HCLK);
      n++;
      got = r ? r1_gnt : r0_gnt;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge HCLK);
      lat++;
      if (lat == drop_after) begin r0_req = 1'b0; r1_req = 1'b0; end
      got = r ? r1_valid : r0_valid;
    end
    chk("valid_seen", 32'(got), 32'd1);
    r0_req = 1'b0;
    r1_req = 1'b0;
  endtask

  int lat;
  int base0, base1;
  int gcyc [4];
  int n;
  bit got;
  bit who;

  initial begin
    r0_req = 0; r1_req = 0; r0_addr = '0; r1_addr = '0;
    r0_req8 = 0; r1_req8 = 0; r0_addr8 = '0; r1_addr8 = '0;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);

    // Reset values
    chk("rst_fcen", 32'(fcen), 32'd1);
    chk("rst_fsclk", 32'(fsclk), 32'd0);
    chk("rst_fdoe", 32'(fdoe), 32'd0);
    chk("rst_fdo", 32'(fdo), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", r0_rdata | r1_rdata, 32'h0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // r1 alone, unaligned address
    do_read(1'b1, 24'h000007, 32'hDEADBEEF, 0, lat);
    chk("t3_lat", 32'(lat), 32'd57);
    chk("t3_cmd", 32'(cmd_log), 32'hEB);
    chk("t3_cmd_hi", 32'(hi_err), 32'd0);
    chk("t3_addr", 32'(addr_log), 32'h000004);
    chk("t3_r1_rdata", r1_rdata, 32'hDEADBEEF);
    chk("t3_r0_rdata", r0_rdata, 32'h0);
    chk("t3_v0", 32'(v0), 32'd0);
    chk("t3_busy_valid", 32'(busy), 32'd1);
    @(negedge HCLK);
    chk("t3_busy_after", 32'(busy), 32'd0);

    // r0 basic read
    do_read(1'b0, 24'h000100, 32'h44332211, 0, lat);
    chk("t1_lat", 32'(lat), 32'd57);
    chk("t1_cmd", 32'(cmd_log), 32'hEB);
    chk("t1_addr", 32'(addr_log), 32'h000100);
    chk("t1_r0_rdata", r0_rdata, 32'h44332211);
    chk("t1_r1_rdata", r1_rdata, 32'hDEADBEEF);
    chk("t1_v1", 32'(v1), 32'd1);

    // Top-of-flash address
    do_read(1'b0, 24'hFFFFFF, 32'h8899AABB, 0, lat);
    chk("top_addr", 32'(addr_log), 32'hFFFFFC);
    chk("top_rdata", r0_rdata, 32'h8899AABB);

    // Request dropped mid-transaction
    do_read(1'b0, 24'h000200, 32'h01234567, 10, lat);
    chk("t5_lat", 32'(lat), 32'd57);
    chk("t5_sck", 32'(sck_last), 32'd28);
    chk("t5_rdata", r0_rdata, 32'h01234567);

    // Round robin from reset with both requests held
    @(negedge HCLK);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    resp_word = 32'hCAFEF00D;
    base0 = v0;
    base1 = v1;
    r0_addr = 24'h000400;
    r1_addr = 24'h000800;
    r0_req = 1'b1;
    r1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 200) begin
        @(negedge HCLK);
        n++;
        got = r0_gnt | r1_gnt;
      end
      who = r1_gnt;
      gcyc[i] = n;
      chk($sformatf("rr_gnt_%0d", i), 32'(got), 32'd1);
      chk($sformatf("rr_order_%0d", i), 32'(who), 32'(i % 2));
      if (i > 0) chk($sformatf("rr_spacing_%0d", i), 32'(gcyc[i]), 32'd59);
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (70) @(negedge HCLK);
    chk("rr_v0", 32'(v0 - base0), 32'd2);
    chk("rr_v1", 32'(v1 - base1), 32'd2);
    chk("rr_rdata", r1_rdata, 32'hCAFEF00D);

    // Reset during DATA
    resp_word = 32'h77777777;
    r0_addr = 24'h000040;
    r0_req = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge HCLK);
      n++;
      got = r0_gnt;
    end
    chk("t4_gnt", 32'(got), 32'd1);
    repeat (45) @(negedge HCLK);
    chk("t4_fcen_active", 32'(fcen), 32'd0);
    chk("t4_fdoe_data", 32'(fdoe), 32'd0);
    base0 = v0;
    HRESETn = 1'b0;
    #1;
    chk("t4_fcen", 32'(fcen), 32'd1);
    chk("t4_fsclk", 32'(fsclk), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    r0_req = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (70) @(negedge HCLK);
    chk("t4_no_valid", 32'(v0 - base0), 32'd0);
    chk("t4_rdata_rst", r0_rdata, 32'h0);
    do_read(1'b0, 24'h000300, 32'h5A5AA5A5, 0, lat);
    chk("t4_fresh_lat", 32'(lat), 32'd57);
    chk("t4_fresh_addr", 32'(addr_log), 32'h000300);
    chk("t4_fresh_rdata", r0_rdata, 32'h5A5AA5A5);

    // DUMMY_CYC=8 instance
    r0_addr8 = 24'h000010;
    r0_req8 = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge HCLK);
      n++;
      got = r0_gnt8;
    end
    chk("t6_gnt", 32'(got), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge HCLK);
      lat++;
      got = r0_valid8;
    end
    r0_req8 = 1'b0;
    chk("t6_lat", 32'(lat), 32'd65);
    chk("t6_rdata", r0_rdata8, 32'hAAAAAAAA);
    chk("t6_dummy_fdoe", 32'(dummy_err), 32'd0);
    chk("t6_sck", 32'(sck8_last), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
